// File: rtl/inst_fetch_queue_if.sv
// Bundles the control, instruction-RAM and consumer signals of inst_fetch_queue.
// The slave modport is the fetch queue; the master modport is its environment.
interface inst_fetch_queue_if #(
    parameter int unsigned INST_LEN      = 220,
    parameter int unsigned INST_ADDR_LEN = 16
);
    logic                     start;
    logic [INST_ADDR_LEN-1:0] st_addr;
    logic [INST_ADDR_LEN-1:0] inst_num;
    logic                     busy;
    logic                     done;
    logic                     imem_rd_en;
    logic [INST_ADDR_LEN-1:0] imem_rd_addr;
    logic [INST_LEN-1:0]      imem_rd_data;
    logic [INST_LEN-1:0]      instruct;
    logic                     inst_empty;
    logic                     inst_req;
    logic                     pop_err;
    logic [31:0]              stall_cnt;

    modport master (
        output start, st_addr, inst_num, imem_rd_data, inst_req,
        input  busy, done, imem_rd_en, imem_rd_addr, instruct, inst_empty, pop_err, stall_cnt
    );

    modport slave (
        input  start, st_addr, inst_num, imem_rd_data, inst_req,
        output busy, done, imem_rd_en, imem_rd_addr, instruct, inst_empty, pop_err, stall_cnt
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Streams a program from the instruction RAM into a first-word-fall-through queue for topcontrol.
// Define INST_FETCH_PERF_EN to build the consumer-starvation counter on stall_cnt.
module inst_fetch_queue #(
    parameter int unsigned INST_LEN      = 220,
    parameter int unsigned INST_ADDR_LEN = 16,
    parameter int unsigned FIFO_AW       = 4,
    parameter int unsigned IMEM_LAT      = 1
) (
    input  logic              clk,
    input  logic              rst,
    inst_fetch_queue_if.slave bus
);
    localparam int unsigned   DEPTH   = 1 << FIFO_AW;
    localparam int unsigned   CW      = FIFO_AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

    state_e                   state_q, state_d;
    logic                     busy_q, done_q, pop_err_q, rd_en_q, empty_q;
    logic [INST_ADDR_LEN-1:0] rd_addr_q, next_addr_q;
    logic [INST_ADDR_LEN-1:0] remain_q, remain_d;
    logic [CW-1:0]            credit_q, credit_d;
    logic [CW-1:0]            count_q, count_d;
    logic [FIFO_AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [IMEM_LAT-1:0]      vld_sr_q, vld_sr_d;
    logic [INST_LEN-1:0]      head_q;
    logic [INST_LEN-1:0]      mem_q [DEPTH];

    logic                     accept, pop, ret, issue, finish;
    logic [INST_ADDR_LEN-1:0] issue_addr;
    logic [CW-1:0]            kept;

    // Credit counts every word issued but not yet popped, so a returning word always has a slot.
    always_comb begin
        accept     = bus.start && (state_q == IDLE);
        pop        = bus.inst_req && !empty_q;
        ret        = vld_sr_q[IMEM_LAT-1];
        issue      = 1'b0;
        issue_addr = next_addr_q;
        remain_d   = remain_q;
        state_d    = state_q;

        if (accept) begin
            issue      = (bus.inst_num != '0);
            issue_addr = bus.st_addr;
            remain_d   = bus.inst_num;
        end else if (state_q == FETCH) begin
            issue = (credit_q - CW'(pop)) < DEPTH_C;
        end
        if (issue) begin
            remain_d = remain_d - INST_ADDR_LEN'(1);
        end
        credit_d = credit_q + CW'(issue) - CW'(pop);

        case (state_q)
            IDLE:    if (accept) state_d = (remain_d != '0) ? FETCH : DRAIN;
            FETCH:   if (remain_d == '0) state_d = DRAIN;
            default: ;
        endcase
        // Completion is judged on post-edge values so done lands right after the final pop.
        finish = (state_d == DRAIN) && (credit_d == '0);
        if (finish) begin
            state_d = IDLE;
        end

        kept     = count_q - CW'(pop);
        count_d  = kept + CW'(ret);
        rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
        wr_ptr_d = wr_ptr_q + FIFO_AW'(ret);

        vld_sr_d = '0;
        vld_sr_d[0] = rd_en_q;
        for (int unsigned i = 1; i < IMEM_LAT; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pop_err_q   <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            next_addr_q <= '0;
            remain_q    <= '0;
            credit_q    <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            vld_sr_q    <= '0;
            head_q      <= '0;
            empty_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            done_q   <= finish;
            rd_en_q  <= issue;
            remain_q <= remain_d;
            credit_q <= credit_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            vld_sr_q <= vld_sr_d;

            if (issue) begin
                rd_addr_q   <= issue_addr;
                next_addr_q <= issue_addr + INST_ADDR_LEN'(1);
            end

            if (finish) begin
                busy_q <= 1'b0;
            end else if (accept) begin
                busy_q <= 1'b1;
            end

            if (accept) begin
                pop_err_q <= 1'b0;
            end else if (bus.inst_req && empty_q) begin
                pop_err_q <= 1'b1;
            end

            // Head comes from storage while older words remain, else straight from the RAM bus.
            if (kept != '0) begin
                head_q <= mem_q[rd_ptr_d];
            end else if (ret) begin
                head_q <= bus.imem_rd_data;
            end
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (ret) begin
            mem_q[wr_ptr_q] <= bus.imem_rd_data;
        end
    end

`ifdef INST_FETCH_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (accept) begin
            stall_q <= '0;
        end else if (busy_q && empty_q && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = '0;
`endif

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.imem_rd_en   = rd_en_q;
    assign bus.imem_rd_addr = rd_addr_q;
    assign bus.instruct     = head_q;
    assign bus.inst_empty   = empty_q;
    assign bus.pop_err      = pop_err_q;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: program table plus random consumers, checked against a timestamped-queue model.
module tb_inst_fetch_queue;
    localparam int unsigned IL    = 220;
    localparam int unsigned AL    = 16;
    localparam int unsigned AW    = 2;
    localparam int unsigned LAT   = 3;
    localparam int          DEPTH = 4;
    localparam int          TMO   = 400;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_queue_if #(.INST_LEN(IL), .INST_ADDR_LEN(AL)) bus ();

    inst_fetch_queue #(
        .INST_LEN(IL), .INST_ADDR_LEN(AL), .FIFO_AW(AW), .IMEM_LAT(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [IL-1:0] word_of(input logic [AL-1:0] a);
        logic [IL-1:0] w;
        w = '0;
        for (int i = 0; i < 13; i++) w[i*16 +: 16] = a ^ 16'(i * 4919);
        w[IL-1 -: 12] = ~a[11:0];
        return w;
    endfunction

    // Instruction RAM: data for the address presented LAT cycles earlier.
    logic [AL-1:0] ram_pipe [LAT];
    always @(posedge clk) begin
        ram_pipe[0] <= bus.imem_rd_addr;
        for (int i = 1; i < int'(LAT); i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    always_comb bus.imem_rd_data = word_of(ram_pipe[LAT-1]);

    typedef struct {
        int            vis;
        logic [IL-1:0] w;
    } ent_t;

    typedef struct {
        logic [AL-1:0] st_addr;
        int            num;
        int            mode;
        int            hold;
        int            exp_reads;
        logic [AL-1:0] exp_last;
        int            exp_held;
        int            exp_lat;
        int            exp_stall;
    } vec_t;

    ent_t          mq[$];
    int            cyc, errors, checks;
    bit            m_active, m_busy, m_done, m_rd, m_err;
    int            m_num, issued, popped;
    logic [AL-1:0] m_base, m_rd_addr;
    logic [31:0]   m_stall;
    vec_t          tbl [7];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic chkw(input string nm, input logic [IL-1:0] got, input logic [IL-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic bit m_empty();
        return (mq.size() == 0) || (mq[0].vis > cyc);
    endfunction

    task automatic model_clear();
        mq.delete();
        m_active = 0; m_busy = 0; m_done = 0; m_rd = 0; m_err = 0;
        m_stall = '0; issued = 0; popped = 0; m_num = 0;
    endtask

    // A word read in cycle k is on the bus in k+LAT and at the queue head from k+LAT+1.
    task automatic model_edge();
        bit pop, acc;
        ent_t e;
        pop = bus.inst_req && !m_empty();
        if (m_busy && m_empty() && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (bus.inst_req && m_empty()) m_err = 1;
        if (pop) begin
            void'(mq.pop_front());
            popped++;
        end
        cyc++;
        acc = bus.start && !m_active;
        if (acc) begin
            m_active = 1; m_num = int'(bus.inst_num); m_base = bus.st_addr;
            issued = 0; popped = 0; m_err = 0; m_stall = '0;
        end
        m_rd = m_active && (issued < m_num) && ((issued - popped) < DEPTH);
        if (m_rd) begin
            m_rd_addr = m_base + AL'(issued);
            e.vis = cyc + int'(LAT) + 1;
            e.w   = word_of(m_rd_addr);
            mq.push_back(e);
            issued++;
        end
        m_done = m_active && (issued == m_num) && (popped == m_num);
        if (m_done) m_active = 0;
        m_busy = m_active;
    endtask

    task automatic compare_all();
        chk("busy", 32'(bus.busy), 32'(m_busy));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("imem_rd_en", 32'(bus.imem_rd_en), 32'(m_rd));
        if (m_rd) chk("imem_rd_addr", 32'(bus.imem_rd_addr), 32'(m_rd_addr));
        chk("inst_empty", 32'(bus.inst_empty), 32'(m_empty()));
        if (!m_empty()) chkw("instruct", bus.instruct, mq[0].w);
        chk("pop_err", 32'(bus.pop_err), 32'(m_err));
`ifdef INST_FETCH_PERF_EN
        chk("stall_cnt", bus.stall_cnt, m_stall);
`else
        chk("stall_cnt", bus.stall_cnt, 32'd0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // mode 0: always ready, 1: random, 2: withhold pops for 'hold' cycles.
    function automatic bit want(input vec_t v, input int c);
        case (v.mode)
            0:       return 1'b1;
            1:       return $urandom_range(0, 1) == 1;
            default: return c >= v.hold;
        endcase
    endfunction

    task automatic run_prog(input vec_t v);
        int            rd_cnt, rd_held, lat;
        bit            fin;
        logic [AL-1:0] last;
        rd_cnt = 0; rd_held = 0; lat = -1; fin = 0; last = '0;
        bus.st_addr  = v.st_addr;
        bus.inst_num = AL'(v.num);
        for (int c = 0; c < TMO && !fin; c++) begin
            bus.start = (c == 0) || (v.mode == 1 && c == 3);
            if (c == 3) bus.st_addr = ~v.st_addr;
            bus.inst_req = want(v, c) && !m_empty();
            step();
            if (bus.imem_rd_en) begin
                rd_cnt++;
                last = bus.imem_rd_addr;
                if (c < v.hold) rd_held++;
            end
            if (bus.done) begin
                fin = 1;
                lat = c + 1;
            end
        end
        bus.start = 0; bus.inst_req = 0;
        chk("done_seen", 32'(fin), 32'd1);
        chk("read_count", 32'(rd_cnt), 32'(v.exp_reads));
        if (v.exp_reads > 0) chk("last_addr", 32'(last), 32'(v.exp_last));
        if (v.exp_held >= 0) chk("reads_while_held", 32'(rd_held), 32'(v.exp_held));
        if (v.exp_lat >= 0) chk("done_latency", 32'(lat), 32'(v.exp_lat));
`ifdef INST_FETCH_PERF_EN
        if (v.exp_stall >= 0) chk("stall_total", bus.stall_cnt, 32'(v.exp_stall));
`endif
        repeat (2) step();
    endtask

    initial begin
        //            st_addr   num mode hold reads last      held lat stall
        tbl[0] = '{16'h0010,  3, 0,  0,  3, 16'h0012, -1,  8, -1};
        tbl[1] = '{16'hFFFE,  4, 0,  0,  4, 16'h0001, -1, -1, -1};
        tbl[2] = '{16'h1234,  0, 0,  0,  0, 16'h0000, -1,  1,  0};
        tbl[3] = '{16'h0100, 10, 2, 20, 10, 16'h0109,  4, -1, -1};
        tbl[4] = '{16'h0040,  1, 0,  0,  1, 16'h0040, -1,  6,  4};
        tbl[5] = '{16'h2000, 17, 1,  0, 17, 16'h2010, -1, -1, -1};
        tbl[6] = '{16'hFFF0, 25, 1,  0, 25, 16'h0008, -1, -1, -1};

        errors = 0; checks = 0; cyc = 0;
        model_clear();
        rst = 1'b1;
        bus.start = 0; bus.st_addr = '0; bus.inst_num = '0; bus.inst_req = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_rd_en", 32'(bus.imem_rd_en), 32'd0);
        chk("rst_rd_addr", 32'(bus.imem_rd_addr), 32'd0);
        chk("rst_empty", 32'(bus.inst_empty), 32'd1);
        chkw("rst_instruct", bus.instruct, '0);
        chk("rst_pop_err", 32'(bus.pop_err), 32'd0);
        chk("rst_stall", bus.stall_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) step();

        for (int t = 0; t < 7; t++) run_prog(tbl[t]);

        for (int r = 0; r < 3; r++) begin
            vec_t v;
            v.st_addr   = AL'($urandom);
            v.num       = int'($urandom_range(1, 30));
            v.mode      = 1;
            v.hold      = 0;
            v.exp_reads = v.num;
            v.exp_last  = v.st_addr + AL'(v.num - 1);
            v.exp_held  = -1;
            v.exp_lat   = -1;
            v.exp_stall = -1;
            run_prog(v);
        end

        // Pop while empty sets the sticky error; the next program start clears it.
        bus.inst_req = 1;
        step();
        bus.inst_req = 0;
        step();
        chk("pop_err_sticky", 32'(bus.pop_err), 32'd1);
        run_prog(tbl[0]);
        chk("pop_err_cleared", 32'(bus.pop_err), 32'd0);

        // Asynchronous reset with two reads outstanding, then a clean restart.
        bus.start = 1; bus.st_addr = 16'h0300; bus.inst_num = 16'd8; bus.inst_req = 0;
        step();
        bus.start = 0;
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_empty", 32'(bus.inst_empty), 32'd1);
        chk("arst_rd_en", 32'(bus.imem_rd_en), 32'd0);
        chk("arst_stall", bus.stall_cnt, 32'd0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) step();
        run_prog('{16'h0300, 8, 0, 0, 8, 16'h0307, -1, -1, -1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
